// File: rtl/iq_mod_pkg.sv
// Shared types and helpers for the fs/4 IQ upconverter: sample format, mixer phase,
// saturating negate and the 29/32 gain-compensation scaler.
package iq_mod_pkg;

  localparam int W              = 5;
  localparam int RATE_DIV_DEF   = 5;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int GW             = W + 5;

  // LSB weight of a sample, for converting to volts in the bench
  localparam real QUANTUM = 0.03226;

  typedef logic signed [W-1:0] sample_t;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  typedef struct packed {
    sample_t i;
    sample_t q;
  } iq_pair_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(W-1){1'b0}}};

  // Two's complement negate with -MIN clamped to MAX instead of wrapping
  function automatic sample_t sat_neg(input sample_t x);
    sample_t r;
    if (x == SAMPLE_MIN) begin
      r = SAMPLE_MAX;
    end else begin
      r = sample_t'(-x);
    end
    return r;
  endfunction

  // Scale by 29/32 with half-up rounding; GW bits hold the full product
  function automatic sample_t gain_comp(input sample_t x);
    logic signed [GW-1:0] acc;
    acc = (GW'(x) * GW'(6'sd29)) + GW'(6'sd16);
    acc = acc >>> 3'd5;
    return acc[W-1:0];
  endfunction

endpackage

// File: rtl/iq_mod_if_if.sv
// Baseband input handshake and DAC-side output bundle of the IQ upconverter.
interface iq_mod_if_if;
  import iq_mod_pkg::*;

  logic    BB_valid_i;
  logic    BB_ready_o;
  sample_t I_BB;
  sample_t Q_BB;
  logic    DAC_rdy_o;
  sample_t I_IF;
  sample_t Q_IF;
  logic    underflow_o;

  modport master (
    output BB_valid_i, I_BB, Q_BB,
    input  BB_ready_o, DAC_rdy_o, I_IF, Q_IF, underflow_o
  );

  modport slave (
    input  BB_valid_i, I_BB, Q_BB,
    output BB_ready_o, DAC_rdy_o, I_IF, Q_IF, underflow_o
  );

endinterface

// File: rtl/iq_mod_fifo.sv
// Small synchronous FIFO of {I,Q} pairs; head is visible combinationally on rd_data.
module iq_mod_fifo
  import iq_mod_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  iq_pair_t                   wr_data,
  output iq_pair_t                   rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  iq_pair_t       mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           push_ok_s;
  logic           pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/iq_mod_if.sv
// fs/4 digital IQ upconverter: buffers baseband pairs, rotates them by 0/90/180/270 deg
// per DAC strobe. Define IQ_MOD_GAIN_COMP_EN to apply 29/32 gain compensation.
module iq_mod_if
  import iq_mod_pkg::*;
#(
  parameter int RATE_DIV   = RATE_DIV_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_en_i,
  iq_mod_if_if.slave bus
);

  localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0] cnt_r;
  logic             strobe_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [CW-1:0]    fill_s;
  iq_pair_t         wr_s;
  iq_pair_t         head_s;
  phase_t           phase_r;
  phase_t           phase_nxt_s;
  sample_t          i_mix_s;
  sample_t          q_mix_s;
  sample_t          i_out_s;
  sample_t          q_out_s;
  sample_t          i_if_r;
  sample_t          q_if_r;
  logic             dac_rdy_r;
  logic             underflow_r;

  // Ready is gated by resetn so it drops the instant reset asserts
  assign bus.BB_ready_o = resetn & (fill_s != CW'(FIFO_DEPTH));
  assign push_s         = bus.BB_valid_i & ~full_s;
  assign wr_s           = '{i: bus.I_BB, q: bus.Q_BB};
  assign strobe_s       = tx_en_i & (cnt_r == CNT_W'(RATE_DIV - 1));
  assign pop_s          = strobe_s & ~empty_s;

  iq_mod_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (wr_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (fill_s)
  );

  // DAC rate divider, held at zero while transmit is disabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= '0;
    end else if (!tx_en_i) begin
      cnt_r <= '0;
    end else if (strobe_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

  // Mixer phase state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_r <= P0;
    end else begin
      phase_r <= phase_nxt_s;
    end
  end

  // Phase advances on every strobe, underflow included
  always_comb begin
    phase_nxt_s = phase_r;
    if (!tx_en_i) begin
      phase_nxt_s = P0;
    end else if (strobe_s) begin
      case (phase_r)
        P0:      phase_nxt_s = P1;
        P1:      phase_nxt_s = P2;
        P2:      phase_nxt_s = P3;
        P3:      phase_nxt_s = P0;
        default: phase_nxt_s = P0;
      endcase
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Multiply by exp(j*pi/2*n): only swaps and saturating negations
  always_comb begin
    i_mix_s = '0;
    q_mix_s = '0;
    case (phase_r)
      P0: begin
        i_mix_s = head_s.i;
        q_mix_s = head_s.q;
      end
      P1: begin
        i_mix_s = sat_neg(head_s.q);
        q_mix_s = head_s.i;
      end
      P2: begin
        i_mix_s = sat_neg(head_s.i);
        q_mix_s = sat_neg(head_s.q);
      end
      P3: begin
        i_mix_s = head_s.q;
        q_mix_s = sat_neg(head_s.i);
      end
      default: begin
        i_mix_s = '0;
        q_mix_s = '0;
      end
    endcase
  end

`ifdef IQ_MOD_GAIN_COMP_EN
  assign i_out_s = gain_comp(i_mix_s);
  assign q_out_s = gain_comp(q_mix_s);
`else
  assign i_out_s = i_mix_s;
  assign q_out_s = q_mix_s;
`endif

  // Output register: loads on strobe, holds otherwise, zeroed while disabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_if_r      <= '0;
      q_if_r      <= '0;
      dac_rdy_r   <= 1'b0;
      underflow_r <= 1'b0;
    end else if (!tx_en_i) begin
      i_if_r      <= '0;
      q_if_r      <= '0;
      dac_rdy_r   <= 1'b0;
      underflow_r <= 1'b0;
    end else if (strobe_s) begin
      dac_rdy_r   <= 1'b1;
      underflow_r <= empty_s;
      if (empty_s) begin
        i_if_r <= '0;
        q_if_r <= '0;
      end else begin
        i_if_r <= i_out_s;
        q_if_r <= q_out_s;
      end
    end else begin
      dac_rdy_r   <= 1'b0;
      underflow_r <= 1'b0;
    end
  end

  assign bus.I_IF        = i_if_r;
  assign bus.Q_IF        = q_if_r;
  assign bus.DAC_rdy_o   = dac_rdy_r;
  assign bus.underflow_o = underflow_r;

endmodule
